ncpu32k_bpu_wb: RTL and testbench

Branch-outcome feedback unit; the writeback end of the branch predictor interface. Fetch records every predicted relative jump (PC, predicted direction, predicted target) into an in-order tracking FIFO. When execute resolves that jump, this block compares the actual outcome against the recorded prediction and drives the predictor's writeback port (bpu_wb, bpu_wb_jmprel, bpu_wb_insn_pc, bpu_wb_hit). On a mispredict it raises a one-cycle pipeline flush with the corrected fetch PC. Sits between the fetch stage, the execute stage and ncpu32k_bpu.

---
 rtl/ncpu32k_bpu_wb.sv | 131 +++++++++++++
 tb/tb_ncpu32k_bpu_wb.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/ncpu32k_bpu_wb.sv
// Branch-outcome feedback: tracks predicted relative jumps in order and trains the predictor on resolve.
// Latency: writeback strobe and mispredict flush appear 1 cycle after the resolve handshake.
// Backpressure: push_ready drops when full or flushing; res_ready drops when empty or flushing.
`ifndef NCPU_AW
`define NCPU_AW 32
`endif

module ncpu32k_bpu_wb #(
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push_valid,
  output logic                    push_ready,
  input  logic [`NCPU_AW-3:0]     push_insn_pc,
  input  logic                    push_taken,
  input  logic [`NCPU_AW-3:0]     push_tgt,
  input  logic                    res_valid,
  output logic                    res_ready,
  input  logic                    res_taken,
  input  logic [`NCPU_AW-3:0]     res_tgt,
  output logic                    flush,
  output logic [`NCPU_AW-3:0]     flush_tgt,
  output logic                    bpu_wb,
  output logic                    bpu_wb_jmprel,
  output logic [`NCPU_AW-3:0]     bpu_wb_insn_pc,
  output logic                    bpu_wb_hit,
  output logic [DEPTH_LOG2:0]     count
);

  localparam int AW    = `NCPU_AW - 2;
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2 + 1;

  // Entry storage; no reset needed since pointers gate every read.
  logic [AW-1:0] pc_mem    [DEPTH];
  logic          taken_mem [DEPTH];
  logic [AW-1:0] tgt_mem   [DEPTH];

  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic          flush_q, flush_d;
  logic [AW-1:0] flush_tgt_q, flush_tgt_d;
  logic          wb_q, wb_d;
  logic [AW-1:0] wb_pc_q, wb_pc_d;
  logic          wb_hit_q, wb_hit_d;

  logic          empty, full, push_fire, res_fire, hit, mispredict;
  logic [DEPTH_LOG2-1:0] widx, ridx;
  logic [AW-1:0] head_pc, head_tgt, head_pc_inc;
  logic          head_taken;

  assign widx  = wptr_q[DEPTH_LOG2-1:0];
  assign ridx  = rptr_q[DEPTH_LOG2-1:0];
  assign empty = (wptr_q == rptr_q);
  // Same slot with differing wrap bit means every slot is occupied.
  assign full  = (wptr_q[PW-1] != rptr_q[PW-1]) && (widx == ridx);

  assign push_ready = !full && !flush_q;
  assign res_ready  = !empty && !flush_q;
  assign push_fire  = push_valid && push_ready;
  assign res_fire   = res_valid && res_ready;

  assign head_pc     = pc_mem[ridx];
  assign head_taken  = taken_mem[ridx];
  assign head_tgt    = tgt_mem[ridx];
  assign head_pc_inc = head_pc + {{(AW-1){1'b0}}, 1'b1};

  // A not-taken branch has no meaningful target, so only direction matters then.
  assign hit        = (res_taken == head_taken) && (!res_taken || (res_tgt == head_tgt));
  assign mispredict = res_fire && !hit;

  assign count          = wptr_q - rptr_q;
  assign flush          = flush_q;
  assign flush_tgt      = flush_tgt_q;
  assign bpu_wb         = wb_q;
  assign bpu_wb_jmprel  = wb_q;
  assign bpu_wb_insn_pc = wb_pc_q;
  assign bpu_wb_hit     = wb_hit_q;

  // Write the new prediction record at the tail.
  always_ff @(posedge clk) begin
    if (push_fire) begin
      pc_mem[widx]    <= push_insn_pc;
      taken_mem[widx] <= push_taken;
      tgt_mem[widx]   <= push_tgt;
    end
  end

  // Next-state: pointer movement, writeback capture and mispredict recovery.
  always_comb begin
    wptr_d      = wptr_q + {{(PW-1){1'b0}}, push_fire};
    rptr_d      = rptr_q + {{(PW-1){1'b0}}, res_fire};
    flush_d     = mispredict;
    flush_tgt_d = flush_tgt_q;
    wb_d        = res_fire;
    wb_pc_d     = wb_pc_q;
    wb_hit_d    = wb_hit_q;
    if (res_fire) begin
      wb_pc_d  = head_pc;
      wb_hit_d = hit;
    end
    if (mispredict) begin
      // Everything younger is wrong-path, including a same-cycle push.
      wptr_d      = '0;
      rptr_d      = '0;
      flush_tgt_d = res_taken ? res_tgt : head_pc_inc;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      flush_q     <= 1'b0;
      flush_tgt_q <= '0;
      wb_q        <= 1'b0;
      wb_pc_q     <= '0;
      wb_hit_q    <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      flush_q     <= flush_d;
      flush_tgt_q <= flush_tgt_d;
      wb_q        <= wb_d;
      wb_pc_q     <= wb_pc_d;
      wb_hit_q    <= wb_hit_d;
    end
  end

endmodule

// File: tb/tb_ncpu32k_bpu_wb.sv
// Scoreboard bench for ncpu32k_bpu_wb: stimulus pushes expected writebacks, a monitor pops them.
`ifndef NCPU_AW
`define NCPU_AW 32
`endif

module tb_ncpu32k_bpu_wb;

  localparam int DL    = 2;
  localparam int DEPTH = 1 << DL;
  localparam int AW    = `NCPU_AW - 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          push_valid = 1'b0, push_taken = 1'b0;
  logic [AW-1:0] push_insn_pc = '0, push_tgt = '0;
  logic          res_valid = 1'b0, res_taken = 1'b0;
  logic [AW-1:0] res_tgt = '0;
  logic          push_ready, res_ready, flush, bpu_wb, bpu_wb_jmprel, bpu_wb_hit;
  logic [AW-1:0] flush_tgt, bpu_wb_insn_pc;
  logic [DL:0]   count;

  ncpu32k_bpu_wb #(.DEPTH_LOG2(DL)) dut (
    .clk(clk), .rst_n(rst_n),
    .push_valid(push_valid), .push_ready(push_ready), .push_insn_pc(push_insn_pc),
    .push_taken(push_taken), .push_tgt(push_tgt),
    .res_valid(res_valid), .res_ready(res_ready), .res_taken(res_taken), .res_tgt(res_tgt),
    .flush(flush), .flush_tgt(flush_tgt),
    .bpu_wb(bpu_wb), .bpu_wb_jmprel(bpu_wb_jmprel), .bpu_wb_insn_pc(bpu_wb_insn_pc),
    .bpu_wb_hit(bpu_wb_hit), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct { logic [AW-1:0] pc; logic taken; logic [AW-1:0] tgt; } ent_t;
  typedef struct { logic [AW-1:0] pc; logic hit; logic [AW-1:0] ftgt; } exp_t;

  ent_t mq[$];   // entries the bench believes are tracked
  exp_t sb[$];   // expected writebacks, oldest first
  logic mflush = 1'b0;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // One clock of stimulus; the reference queue decides which handshakes fire.
  task automatic step(input logic pv, input logic [AW-1:0] ppc, input logic pt,
                      input logic [AW-1:0] ptgt, input logic rv, input logic rt,
                      input logic [AW-1:0] rtgt);
    logic m_pr, m_rr, pf, rf, h;
    ent_t e, n;
    exp_t x;
    push_valid = pv; push_insn_pc = ppc; push_taken = pt; push_tgt = ptgt;
    res_valid = rv; res_taken = rt; res_tgt = rtgt;
    m_pr = (mq.size() < DEPTH) && !mflush;
    m_rr = (mq.size() > 0) && !mflush;
    @(negedge clk);
    chk("push_ready", {31'b0, push_ready}, {31'b0, m_pr});
    chk("res_ready", {31'b0, res_ready}, {31'b0, m_rr});
    chk("count", {29'b0, count}, mq.size());
    pf = pv && m_pr;
    rf = rv && m_rr;
    @(posedge clk);
    mflush = 1'b0;
    if (rf) begin
      e = mq.pop_front();
      h = (rt == e.taken) && (!rt || rtgt == e.tgt);
      x.pc = e.pc; x.hit = h; x.ftgt = rt ? rtgt : e.pc + 1'b1;
      sb.push_back(x);
      if (!h) begin
        mq.delete();
        mflush = 1'b1;
        pf = 1'b0;
      end
    end
    if (pf) begin
      n.pc = ppc; n.taken = pt; n.tgt = ptgt;
      mq.push_back(n);
    end
    #1;
    push_valid = 1'b0; res_valid = 1'b0;
  endtask

  task automatic idle();
    step(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, '0);
  endtask

  task automatic push(input logic [AW-1:0] pc, input logic t, input logic [AW-1:0] tg);
    step(1'b1, pc, t, tg, 1'b0, 1'b0, '0);
  endtask

  task automatic resolve(input logic t, input logic [AW-1:0] tg);
    step(1'b0, '0, 1'b0, '0, 1'b1, t, tg);
  endtask

  // Monitor: every strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t x;
    if (rst_n) begin
      chk("jmprel_eq_wb", {31'b0, bpu_wb_jmprel}, {31'b0, bpu_wb});
      if (bpu_wb) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_wb: strobe with pc 0x%0h, expected none (t=%0t)", bpu_wb_insn_pc, $time);
        end else begin
          x = sb.pop_front();
          chk("wb_pc", bpu_wb_insn_pc, x.pc);
          chk("wb_hit", {31'b0, bpu_wb_hit}, {31'b0, x.hit});
          chk("wb_flush", {31'b0, flush}, {31'b0, !x.hit});
          if (!x.hit) chk("wb_flush_tgt", flush_tgt, x.ftgt);
        end
      end else begin
        chk("flush_idle", {31'b0, flush}, 32'd0);
      end
    end
  end

  initial begin
    // Reset then idle
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_count", {29'b0, count}, 0);
    chk("rst_push_ready", {31'b0, push_ready}, 1);
    chk("rst_res_ready", {31'b0, res_ready}, 0);
    chk("rst_flush", {31'b0, flush}, 0);
    chk("rst_flush_tgt", flush_tgt, 0);
    chk("rst_wb", {31'b0, bpu_wb}, 0);
    chk("rst_jmprel", {31'b0, bpu_wb_jmprel}, 0);
    chk("rst_wb_pc", bpu_wb_insn_pc, 0);
    chk("rst_wb_hit", {31'b0, bpu_wb_hit}, 0);
    idle();

    // Correct prediction
    push(30'h100, 1'b1, 30'h140);
    resolve(1'b1, 30'h140);
    chk("hit_wb", {31'b0, bpu_wb}, 1);
    chk("hit_jmprel", {31'b0, bpu_wb_jmprel}, 1);
    chk("hit_pc", bpu_wb_insn_pc, 32'h100);
    chk("hit_hit", {31'b0, bpu_wb_hit}, 1);
    chk("hit_flush", {31'b0, flush}, 0);
    chk("hit_count", {29'b0, count}, 0);
    idle();
    chk("hit_pc_hold", bpu_wb_insn_pc, 32'h100);
    chk("wb_one_cycle", {31'b0, bpu_wb}, 0);

    // Direction mispredict discards the younger entry
    push(30'h200, 1'b1, 30'h180);
    push(30'h210, 1'b0, 30'h0);
    resolve(1'b0, 30'h0);
    chk("dir_hit", {31'b0, bpu_wb_hit}, 0);
    chk("dir_flush", {31'b0, flush}, 1);
    chk("dir_flush_tgt", flush_tgt, 32'h201);
    chk("dir_count", {29'b0, count}, 0);
    chk("dir_push_ready", {31'b0, push_ready}, 0);
    chk("dir_res_ready", {31'b0, res_ready}, 0);
    idle();
    chk("dir_push_ready_after", {31'b0, push_ready}, 1);
    chk("dir_flush_one_cycle", {31'b0, flush}, 0);
    chk("dir_flush_tgt_hold", flush_tgt, 32'h201);

    // Target mispredict
    push(30'h300, 1'b1, 30'h340);
    resolve(1'b1, 30'h344);
    chk("tgt_flush", {31'b0, flush}, 1);
    chk("tgt_flush_tgt", flush_tgt, 32'h344);
    chk("tgt_hit", {31'b0, bpu_wb_hit}, 0);
    idle();

    // No bypass: push and resolve on empty FIFO, then not-taken hit with stray target
    step(1'b1, 30'h600, 1'b0, 30'h0, 1'b1, 1'b0, 30'h123);
    chk("nobypass_count", {29'b0, count}, 1);
    chk("nobypass_wb", {31'b0, bpu_wb}, 0);
    resolve(1'b0, 30'h123);
    chk("nt_hit", {31'b0, bpu_wb_hit}, 1);
    chk("nt_flush", {31'b0, flush}, 0);
    idle();

    // Full, then wrap-around
    for (int i = 0; i < 4; i++) push(30'h400 + i, 1'b1, 30'h410 + i);
    chk("full_count", {29'b0, count}, 4);
    chk("full_push_ready", {31'b0, push_ready}, 0);
    step(1'b1, 30'h4ff, 1'b1, 30'h0, 1'b1, 1'b1, 30'h410);
    chk("full_pop_count", {29'b0, count}, 3);
    for (int i = 0; i < 10; i++)
      step(1'b1, 30'h500 + i, i[0], 30'h540 + i, 1'b1, mq[0].taken, mq[0].tgt);
    chk("wrap_count", {29'b0, count}, 3);
    for (int i = 0; i < 3; i++) resolve(mq[0].taken, mq[0].tgt);
    chk("drain_count", {29'b0, count}, 0);
    idle();

    // Reset mid-flight
    for (int i = 0; i < 3; i++) push(30'h700 + i, 1'b1, 30'h740);
    chk("mid_count_before", {29'b0, count}, 3);
    rst_n = 1'b0;
    mq.delete();
    mflush = 1'b0;
    #2;
    chk("mid_count", {29'b0, count}, 0);
    chk("mid_wb", {31'b0, bpu_wb}, 0);
    chk("mid_flush", {31'b0, flush}, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) idle();
    chk("mid_count_after", {29'b0, count}, 0);

    repeat (2) @(posedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
